// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch controller.
//   INST_ADDR_WIDTH / INST_DATA_WIDTH : instruction address / word widths
//   RESET_PC_DEFAULT                  : default fetch PC loaded on reset
//   PC_INC                            : sequential fetch increment (one word)
//   fetch_state_e                     : fetch FSM encoding
//   fetch_entry_t                     : one prefetch buffer entry {pc, inst}
package if_fetch_ctrl_pkg;

    localparam int unsigned INST_ADDR_WIDTH = 32;
    localparam int unsigned INST_DATA_WIDTH = 32;

    localparam logic [INST_ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_ADDR_WIDTH-1:0] PC_INC           = 32'd4;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic [INST_DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its environment.
//   fetch_en, redirect_valid, redirect_pc : control from the pipeline
//   rom_ce, rom_addr, rom_inst            : combinational instruction ROM port
//   out_valid, out_ready, out_pc, out_inst: valid/ready handshake to decode
// master = fetch controller side, slave = environment (ROM, decode, pipeline).
interface if_fetch_ctrl_if;
    import if_fetch_ctrl_pkg::*;

    logic                       fetch_en;
    logic                       redirect_valid;
    logic [INST_ADDR_WIDTH-1:0] redirect_pc;
    logic                       rom_ce;
    logic [INST_ADDR_WIDTH-1:0] rom_addr;
    logic [INST_DATA_WIDTH-1:0] rom_inst;
    logic                       out_valid;
    logic                       out_ready;
    logic [INST_ADDR_WIDTH-1:0] out_pc;
    logic [INST_DATA_WIDTH-1:0] out_inst;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, rom_inst, out_ready,
        output rom_ce, rom_addr, out_valid, out_pc, out_inst
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, rom_inst, out_ready,
        input  rom_ce, rom_addr, out_valid, out_pc, out_inst
    );

endinterface

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Two-entry synchronous prefetch FIFO of {pc, inst}.
//   i_clk, i_rst : clock, synchronous active-high reset (clears storage too)
//   i_push       : write i_entry at the tail (caller guarantees not full)
//   i_pop        : retire the head (caller guarantees not empty)
//   i_flush      : drop all entries; wins over push and pop
//   i_entry      : entry to write
//   o_count      : number of valid entries (0..2)
//   o_head       : head entry storage, shown even when empty
module if_fetch_ctrl_fetch_fifo
    import if_fetch_ctrl_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_head_ptr;
    logic         r_tail_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_count    <= 2'd0;
        end else if (i_flush) begin
            // Storage is left as-is; only the bookkeeping is cleared.
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_tail_ptr] <= i_entry;
                r_tail_ptr        <= ~r_tail_ptr;
            end
            if (i_pop) begin
                r_head_ptr <= ~r_head_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_head_ptr];

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues reads to a
// combinational instruction ROM, buffers returned words in a 2-entry
// prefetch FIFO and hands them to decode over valid/ready. Redirects flush
// the buffer and restart fetch at the (word-aligned) target.
//   i_clk, i_rst : clock, synchronous active-high reset
//   io_bus       : fetch control, ROM port and decode handshake (master side)
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned                ADDR_W   = INST_ADDR_WIDTH,
    parameter int unsigned                DATA_W   = INST_DATA_WIDTH,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned                DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    if_fetch_ctrl_if.master io_bus
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_count;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_unused_redirect_lsb;

    // Low address bits are forced to zero, so the incoming ones are ignored.
    assign w_redirect_pc         = {io_bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_redirect_lsb = ^io_bus.redirect_pc[1:0];

    // Issue only from registered state; a redirect cycle never issues.
    assign w_push = (r_state == StRun) && (w_count < 2'(DEPTH)) && !io_bus.redirect_valid;
    assign w_pop  = (w_count != 2'd0) && io_bus.out_ready;

    assign w_entry.pc   = r_fetch_pc;
    assign w_entry.inst = io_bus.rom_inst[DATA_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            case (r_state)
                StIdle:  if (io_bus.fetch_en) r_state <= StRun;
                StRun:   if (!io_bus.fetch_en) r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (io_bus.redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_INC;  // wraps modulo 2^ADDR_W
        end
    end

    // A pop in a redirect cycle still completes; the flush then clears all.
    if_fetch_ctrl_fetch_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (io_bus.redirect_valid),
        .i_entry (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign io_bus.rom_ce    = w_push;
    assign io_bus.rom_addr  = r_fetch_pc;
    assign io_bus.out_valid = (w_count != 2'd0);
    assign io_bus.out_pc    = w_head.pc;
    assign io_bus.out_inst  = w_head.inst;

endmodule
